// File: rtl/nios_sram_arbiter.sv
// SRAM access controller shared by the Nios Avalon-MM slave port and a req/ack stream port.
// Each access runs IDLE -> SETUP -> ACCESS (WAIT_CYCLES clocks) -> DONE with registered pin outputs.
module nios_sram_arbiter #(
  parameter int ADDR_W      = 11,
  parameter int DATA_W      = 16,
  parameter int WAIT_CYCLES = 2
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [ADDR_W-1:0] avs_address,
  input  logic              avs_chipselect,
  input  logic              avs_read,
  input  logic              avs_write,
  input  logic [DATA_W-1:0] avs_writedata,
  output logic [DATA_W-1:0] avs_readdata,
  output logic              avs_waitrequest,
  input  logic              str_req,
  input  logic              str_we,
  input  logic [ADDR_W-1:0] str_addr,
  input  logic [DATA_W-1:0] str_wdata,
  output logic              str_ack,
  output logic [DATA_W-1:0] str_rdata,
  output logic [ADDR_W-1:0] sram_addr,
  output logic [DATA_W-1:0] sram_dq_out,
  output logic              sram_dq_oe,
  input  logic [DATA_W-1:0] sram_dq_in,
  output logic              sram_ce_n,
  output logic              sram_oe_n,
  output logic              sram_we_n
);

  localparam int WAIT_EFF = (WAIT_CYCLES < 1) ? 1 : WAIT_CYCLES;
  localparam int CNT_W    = (WAIT_EFF < 2) ? 1 : $clog2(WAIT_EFF);
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(WAIT_EFF - 1);
  localparam logic GRANT_HOST   = 1'b0;
  localparam logic GRANT_STREAM = 1'b1;

  typedef enum logic [1:0] {IDLE, SETUP, ACCESS, DONE} state_t;

  state_t            state_q;
  logic              grant_q;
  logic              last_grant_q;
  logic              we_q;
  logic [CNT_W-1:0]  cnt_q;
  logic [ADDR_W-1:0] sram_addr_q;
  logic [DATA_W-1:0] sram_dq_out_q;
  logic              sram_dq_oe_q;
  logic              sram_ce_n_q;
  logic              sram_oe_n_q;
  logic              sram_we_n_q;
  logic              str_ack_q;
  logic [DATA_W-1:0] str_rdata_q;
  logic [DATA_W-1:0] avs_readdata_q;

  logic              hreq;
  logic              host_wins;
  logic              grant_d;
  logic              we_d;
  logic [ADDR_W-1:0] addr_d;
  logic [DATA_W-1:0] wdata_d;

  assign hreq = avs_chipselect & (avs_read | avs_write);

  // On a tie the requester that did not win last time gets the SRAM.
  assign host_wins = hreq & (~str_req | (last_grant_q == GRANT_STREAM));

  always_comb begin
    grant_d = host_wins ? GRANT_HOST : GRANT_STREAM;
    we_d    = host_wins ? avs_write : str_we;
    addr_d  = host_wins ? avs_address : str_addr;
    wdata_d = host_wins ? avs_writedata : str_wdata;
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q        <= IDLE;
      grant_q        <= GRANT_HOST;
      last_grant_q   <= GRANT_STREAM;
      we_q           <= 1'b0;
      cnt_q          <= '0;
      sram_addr_q    <= '0;
      sram_dq_out_q  <= '0;
      sram_dq_oe_q   <= 1'b0;
      sram_ce_n_q    <= 1'b1;
      sram_oe_n_q    <= 1'b1;
      sram_we_n_q    <= 1'b1;
      str_ack_q      <= 1'b0;
      str_rdata_q    <= '0;
      avs_readdata_q <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (hreq || str_req) begin
            grant_q      <= grant_d;
            last_grant_q <= grant_d;
            we_q         <= we_d;
            sram_addr_q  <= addr_d;
            sram_ce_n_q  <= 1'b0;
            if (we_d) begin
              sram_dq_oe_q  <= 1'b1;
              sram_dq_out_q <= wdata_d;
            end
            state_q <= SETUP;
          end
        end
        SETUP: begin
          cnt_q       <= CNT_LOAD;
          sram_oe_n_q <= we_q;
          sram_we_n_q <= ~we_q;
          state_q     <= ACCESS;
        end
        ACCESS: begin
          if (cnt_q == '0) begin
            sram_ce_n_q <= 1'b1;
            sram_oe_n_q <= 1'b1;
            sram_we_n_q <= 1'b1;
            if (!we_q) begin
              if (grant_q == GRANT_HOST) avs_readdata_q <= sram_dq_in;
              else                       str_rdata_q    <= sram_dq_in;
            end
            str_ack_q <= (grant_q == GRANT_STREAM);
            state_q   <= DONE;
          end else begin
            cnt_q <= cnt_q - CNT_W'(1);
          end
        end
        DONE: begin
          // Write data stays driven through DONE for hold time.
          str_ack_q    <= 1'b0;
          sram_dq_oe_q <= 1'b0;
          state_q      <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign avs_waitrequest = hreq & (~reset_n | ~((state_q == DONE) && (grant_q == GRANT_HOST)));
  assign avs_readdata    = avs_readdata_q;
  assign str_ack         = str_ack_q;
  assign str_rdata       = str_rdata_q;
  assign sram_addr       = sram_addr_q;
  assign sram_dq_out     = sram_dq_out_q;
  assign sram_dq_oe      = sram_dq_oe_q;
  assign sram_ce_n       = sram_ce_n_q;
  assign sram_oe_n       = sram_oe_n_q;
  assign sram_we_n       = sram_we_n_q;

endmodule
